// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change path.
// Imported by the change arbiter and its hopper timer.
package vm_pkg;

   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] MAX_COINS = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RELEASE,
      S_JAM
   } arb_state_e;

   function automatic logic [CNT_W-1:0] sat_coins(
      input logic [CNT_W-1:0] c
   );
      return (c > MAX_COINS) ? MAX_COINS : c;
   endfunction

endpackage

// File: rtl/hop_timer.sv
// Counts cycles spent waiting for a hopper acknowledge.
// expired is high in the TIMEOUT-th enabled cycle after start.
module hop_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = '0;
      else if (enable && !expired)
         cnt_d = cnt_q + 8'd1;
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/change_arbiter.sv
// Shares one coin hopper between two vending units, round-robin,
// one coin per 4-phase req/ack handshake, with a sticky jam detector.
module change_arbiter
   import vm_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] chg0,
   input  logic             ld0,
   input  logic [CNT_W-1:0] chg1,
   input  logic             ld1,
   input  logic             hop_ack,
   output logic             hop_req,
   output logic             hop_id,
   output logic             busy0,
   output logic             busy1,
   output logic             done0,
   output logic             done1,
   output logic             jam
);

   arb_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic id_q, id_d;
   logic last_q, last_d;
   logic done0_q, done0_d;
   logic done1_q, done1_d;

   logic b0, b1, any_busy, gnt;
   logic acc0, acc1, rel_dec, dec0, dec1;
   logic cnt_g_one;
   logic tmr_start, tmr_en, tmr_exp;

   assign b0       = |cnt0_q;
   assign b1       = |cnt1_q;
   assign any_busy = b0 | b1;

   // On a tie the unit not served last wins.
   assign gnt = (b0 && b1) ? ~last_q : b1;

   assign acc0 = ld0 && !b0;
   assign acc1 = ld1 && !b1;

   assign rel_dec = (state_q == S_RELEASE) && !hop_ack;
   assign dec0    = rel_dec && !id_q;
   assign dec1    = rel_dec &&  id_q;

   assign cnt_g_one = id_q ? (cnt1_q == CNT_W'(1))
                           : (cnt0_q == CNT_W'(1));

   hop_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (tmr_start),
      .enable  (tmr_en),
      .expired (tmr_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_busy) state_d = S_REQ;
         end
         S_REQ: begin
            if (hop_ack)      state_d = S_RELEASE;
            else if (tmr_exp) state_d = S_JAM;
         end
         S_RELEASE: begin
            if (!hop_ack)
               state_d = cnt_g_one ? S_IDLE : S_REQ;
         end
         S_JAM: begin
            state_d = S_JAM;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hop_req   = (state_q == S_REQ);
      jam       = (state_q == S_JAM);
      hop_id    = id_q;
      busy0     = b0;
      busy1     = b1;
      done0     = done0_q;
      done1     = done1_q;
      tmr_en    = (state_q == S_REQ);
      tmr_start = (state_d == S_REQ) && (state_q != S_REQ);
   end

   always_comb begin
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      id_d    = id_q;
      last_d  = last_q;
      if (acc0)      cnt0_d = sat_coins(chg0);
      else if (dec0) cnt0_d = cnt0_q - CNT_W'(1);
      if (acc1)      cnt1_d = sat_coins(chg1);
      else if (dec1) cnt1_d = cnt1_q - CNT_W'(1);
      // A zero-coin load completes at once without touching the hopper.
      done0_d = (acc0 && (chg0 == '0)) ||
                (dec0 && (cnt0_q == CNT_W'(1)));
      done1_d = (acc1 && (chg1 == '0)) ||
                (dec1 && (cnt1_q == CNT_W'(1)));
      if ((state_q == S_IDLE) && any_busy) begin
         id_d   = gnt;
         last_d = gnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         id_q    <= id_d;
         last_q  <= last_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

endmodule

// File: tb/tb_change_arbiter.sv
// Directed bench for change_arbiter: load table plus
// hand sequences for latency, jam, reset and queueing.
module tb_change_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] chg0 = 3'd0;
   logic [2:0] chg1 = 3'd0;
   logic       ld0 = 1'b0;
   logic       ld1 = 1'b0;
   logic       hop_ack = 1'b0;
   logic       hop_req, hop_id;
   logic       busy0, busy1, done0, done1, jam;

   int checks = 0;
   int errors = 0;

   int   coins0 = 0, coins1 = 0;
   int   dn0 = 0, dn1 = 0;
   int   dc0 = 0, dc1 = 0;
   int   cyc = 0;
   int   wcnt = 0;
   logic req_prev = 1'b0;
   bit   hop_en = 1'b1;

   change_arbiter #(
      .TIMEOUT (15)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .chg0    (chg0),
      .ld0     (ld0),
      .chg1    (chg1),
      .ld1     (ld1),
      .hop_ack (hop_ack),
      .hop_req (hop_req),
      .hop_id  (hop_id),
      .busy0   (busy0),
      .busy1   (busy1),
      .done0   (done0),
      .done1   (done1),
      .jam     (jam)
   );

   always #5 clk = ~clk;

   // Hopper model (acks 2 cycles after req) and event monitor.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         hop_ack  <= 1'b0;
         wcnt     <= 0;
         req_prev <= 1'b0;
         coins0   <= 0;
         coins1   <= 0;
         dn0      <= 0;
         dn1      <= 0;
         dc0      <= 0;
         dc1      <= 0;
      end else begin
         req_prev <= hop_req;
         if (hop_req && !req_prev) begin
            if (hop_id) coins1 <= coins1 + 1;
            else        coins0 <= coins0 + 1;
         end
         if (done0) begin
            dn0 <= dn0 + 1;
            dc0 <= cyc;
         end
         if (done1) begin
            dn1 <= dn1 + 1;
            dc1 <= cyc;
         end
         if (!hop_en || !hop_req) begin
            hop_ack <= 1'b0;
            wcnt    <= 0;
         end else if (!hop_ack) begin
            if (wcnt == 1) hop_ack <= 1'b1;
            else           wcnt    <= wcnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      ld0 = 1'b0;
      ld1 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load(input bit l0, input logic [2:0] c0,
                       input bit l1, input logic [2:0] c1);
      ld0  = l0;
      chg0 = c0;
      ld1  = l1;
      chg1 = c1;
      @(negedge clk);
      ld0 = 1'b0;
      ld1 = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy0 || busy1 || hop_req || hop_ack) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", int'(n < 400), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_coins0(input int target);
      int n = 0;
      while (coins0 < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("coin_wait", int'(n < 200), 1);
   endtask

   typedef struct {
      bit         l0;
      logic [2:0] c0;
      bit         l1;
      logic [2:0] c1;
      int         ec0;
      int         ec1;
      int         ed0;
      int         ed1;
   } vec_t;

   vec_t vt[8];

   initial begin
      int n;
      int cnt;

      vt[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 3, 0, 1, 0};
      vt[1] = '{1'b1, 3'd2, 1'b1, 3'd1, 2, 1, 1, 1};
      vt[2] = '{1'b0, 3'd0, 1'b1, 3'd0, 0, 0, 0, 1};
      vt[3] = '{1'b1, 3'd7, 1'b0, 3'd0, 4, 0, 1, 0};
      vt[4] = '{1'b0, 3'd0, 1'b1, 3'd5, 0, 4, 0, 1};
      vt[5] = '{1'b1, 3'd4, 1'b1, 3'd6, 4, 4, 1, 1};
      vt[6] = '{1'b1, 3'd0, 1'b1, 3'd0, 0, 0, 1, 1};
      vt[7] = '{1'b0, 3'd0, 1'b1, 3'd1, 0, 1, 0, 1};

      // Reset values while rst is held.
      #1;
      chk("reset_outs",
          int'({hop_req, hop_id, busy0, busy1, done0, done1, jam}), 0);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         load(vt[i].l0, vt[i].c0, vt[i].l1, vt[i].c1);
         wait_idle();
         chk($sformatf("v%0d_coins0", i), coins0, vt[i].ec0);
         chk($sformatf("v%0d_coins1", i), coins1, vt[i].ec1);
         chk($sformatf("v%0d_done0", i), dn0, vt[i].ed0);
         chk($sformatf("v%0d_done1", i), dn1, vt[i].ed1);
         chk($sformatf("v%0d_jam", i), int'(jam), 0);
         if (vt[i].ec0 > 0 && vt[i].ec1 > 0)
            chk($sformatf("v%0d_u0_first", i), int'(dc0 < dc1), 1);
      end

      // Zero-coin load: done the next cycle, no hopper activity.
      do_reset();
      load(1'b0, 3'd0, 1'b1, 3'd0);
      chk("zero_done1", int'(done1), 1);
      chk("zero_busy1", int'(busy1), 0);
      chk("zero_req", int'(hop_req), 0);
      @(negedge clk);
      chk("zero_done1_pulse", int'(done1), 0);
      repeat (5) @(negedge clk);
      chk("zero_coins", coins1, 0);

      // hop_req rises the cycle after the grant decision.
      do_reset();
      load(1'b1, 3'd1, 1'b0, 3'd0);
      chk("lat_busy0", int'(busy0), 1);
      chk("lat_req_low", int'(hop_req), 0);
      @(negedge clk);
      chk("lat_req_high", int'(hop_req), 1);
      chk("lat_id", int'(hop_id), 0);
      wait_idle();
      chk("lat_done0", dn0, 1);

      // Jam: ack never comes.
      hop_en = 1'b0;
      do_reset();
      load(1'b1, 3'd1, 1'b0, 3'd0);
      n   = 0;
      cnt = 0;
      while (!jam && n < 60) begin
         @(negedge clk);
         if (hop_req) cnt++;
         n++;
      end
      chk("jam_req_cycles", cnt, 15);
      chk("jam_flag", int'(jam), 1);
      chk("jam_req_low", int'(hop_req), 0);
      chk("jam_busy0", int'(busy0), 1);
      load(1'b0, 3'd0, 1'b1, 3'd2);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (hop_req) cnt++;
      end
      chk("jam_load_busy1", int'(busy1), 1);
      chk("jam_no_payout", cnt, 0);
      chk("jam_sticky", int'(jam), 1);
      chk("jam_busy0_held", int'(busy0), 1);
      rst = 1'b1;
      #1;
      chk("jam_rst_outs",
          int'({hop_req, hop_id, busy0, busy1, done0, done1, jam}), 0);
      @(negedge clk);
      rst = 1'b0;
      hop_en = 1'b1;
      @(negedge clk);

      // Reset in the middle of a 4-coin payout.
      do_reset();
      load(1'b1, 3'd4, 1'b0, 3'd0);
      wait_coins0(2);
      chk("mid_busy0", int'(busy0), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs",
          int'({hop_req, hop_id, busy0, busy1, done0, done1, jam}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid_no_coins", coins0, 0);
      chk("mid_no_done", dn0, 0);
      chk("mid_idle_busy", int'(busy0), 0);

      // Reload while busy is ignored; other unit queues behind.
      do_reset();
      load(1'b1, 3'd4, 1'b0, 3'd0);
      wait_coins0(3);
      load(1'b1, 3'd4, 1'b1, 3'd2);
      wait_idle();
      chk("busy_ld_coins0", coins0, 4);
      chk("busy_ld_done0", dn0, 1);
      chk("queue_coins1", coins1, 2);
      chk("queue_done1", dn1, 1);
      chk("queue_order", int'(dc0 < dc1), 1);

      // Round robin: after unit 0 is served, unit 1 wins the tie.
      do_reset();
      load(1'b1, 3'd1, 1'b0, 3'd0);
      wait_idle();
      load(1'b1, 3'd1, 1'b1, 3'd1);
      wait_idle();
      chk("rr_coins0", coins0, 2);
      chk("rr_coins1", coins1, 1);
      chk("rr_u1_first", int'(dc1 < dc0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_arbiter.md
CHANGE_ARBITER -- requirements
Module: change_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles hop_req waits for hop_ack high before a jam is declared (range 2..255).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 chg0  input  3  change count from vending unit 0 (0..4 coins); sampled only when ld0=1.
REQ-005 ld0  input  1  one-cycle load strobe from unit 0.
REQ-006 chg1  input  3  change count from vending unit 1; sampled only when ld1=1.
REQ-007 ld1  input  1  one-cycle load strobe from unit 1.
REQ-008 hop_ack  input  1  coin hopper acknowledge (4-phase handshake).
REQ-009 hop_req  output  1  coin hopper request; one full req/ack cycle SHALL eject exactly one coin.
REQ-010 hop_id  output  1  index of the unit currently granted; valid while hop_req=1.
REQ-011 busy0, busy1  output  1 each  unit has a payout pending or in progress.
REQ-012 done0, done1  output  1 each  one-cycle pulse when that unit's payout completes.
REQ-013 jam  output  1  sticky hopper-jam flag.

Function
REQ-014 A load with ld_i=1, chg_i!=0 and busy_i=0 SHALL latch chg_i into pending counter cnt_i and set busy_i from the next cycle.
REQ-015 A load with ld_i=1 while busy_i=1 SHALL be ignored; cnt_i SHALL be unchanged.
REQ-016 A load with chg_i=0 SHALL leave busy_i low and pulse done_i in the next cycle without any hopper activity.
REQ-017 chg_i values 5..7 SHALL be saturated to 4.
REQ-018 The FSM SHALL have states IDLE, REQ, RELEASE and JAM; the reset state is IDLE.
REQ-019 In IDLE, if any busy_i=1, the FSM SHALL grant one unit and move to REQ; hop_req SHALL rise in the cycle after the grant decision.
REQ-020 Arbitration SHALL be round-robin: if both units are pending, the unit not served last SHALL be granted; the last-served pointer SHALL reset to unit 1, so unit 0 wins the first tie.
REQ-021 A grant SHALL be held for the whole payout (all coins of cnt_i); it SHALL not be pre-empted.
REQ-022 In REQ, hop_req=1; when hop_ack=1, the FSM SHALL move to RELEASE and drop hop_req.
REQ-023 In RELEASE, when hop_ack=0, cnt_i SHALL decrement by 1; if the result is 0, busy_i SHALL clear, done_i SHALL pulse in the same cycle, and the FSM SHALL return to IDLE; otherwise the FSM SHALL return to REQ.
REQ-024 Each REQ entry SHALL restart a cycle counter; if TIMEOUT cycles elapse in REQ without hop_ack, the FSM SHALL enter JAM.
REQ-025 In JAM: hop_req=0, jam=1, and no further payouts SHALL start; pending counts and busy flags SHALL be held; JAM SHALL be left only by rst.
REQ-026 Loads SHALL be accepted in every state, including JAM, subject to REQ-014 to REQ-016.
REQ-027 A load to the ungranted unit during another unit's payout SHALL be queued and served after the current payout completes.
REQ-028 Simultaneous ld0 and ld1 SHALL both be accepted.

Reset
REQ-029 rst SHALL force state=IDLE, cnt0=cnt1=0, hop_req=0, hop_id=0, busy0=busy1=0, done0=done1=0, jam=0, last-served pointer=1, and timeout counter=0.
REQ-030 Assertion of rst mid-payout SHALL abandon the payout immediately; no done pulse SHALL be issued.

Structure
REQ-031 The state enum, the coin-count width (3) and the maximum-coins constant (4) SHALL reside in a shared package, vm_pkg.
REQ-032 The timeout counter SHALL be a sub-module, hop_timer (inputs: start, enable; output: expired).

Verification
REQ-033 ld0 with chg0=3, hopper acks 2 cycles after each req -> exactly 3 hop_req pulses with hop_id=0, then done0 for 1 cycle, busy0=0.
REQ-034 ld0 with chg0=2 and ld1 with chg1=1 in the same cycle -> unit 0 paid 2 coins first, then unit 1 paid 1 coin; done0 precedes done1.
REQ-035 ld1 with chg1=0 -> done1 next cycle, hop_req stays 0.
REQ-036 ld0 with chg0=1, hop_ack held 0 -> jam=1 after 15 cycles in REQ, hop_req=0, busy0 stays 1 until rst.
REQ-037 rst asserted while the second of 4 coins is pending -> all outputs 0 immediately, no done0 pulse.
REQ-038 ld0 with chg0=4 while busy0=1 and cnt0=2 -> load ignored; only 2 further coins are paid.
